// File: rtl/spike_pkg.sv
// Shared definitions for the spike receivers: FSM state encoding, default widths
// and saturation limits for the default widths.
package spike_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned WIN_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned ISI_W_DEF = 8;

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
  localparam logic [ISI_W_DEF-1:0] ISI_MAX = '1;

endpackage

// File: rtl/spike_edge_sync.sv
// Two-flop synchronizer for an asynchronous spike train followed by a rising-edge
// detector; spike_edge is a one-cycle pulse per low-to-high transition.
module spike_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_in,
  output logic spike_edge
);

  logic sync1, sync2, sync3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= spike_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign spike_edge = sync2 & ~sync3;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike rising edges over a programmable window and hands the count out via
// valid/ready. Optional inter-spike-interval measurement when SPIKE_ISI_EN is defined.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int unsigned WIN_W = WIN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ISI_W = ISI_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             busy,
  output logic             saturated,
  output logic             overrun,
  output logic [ISI_W-1:0] isi_out
);

  localparam logic [CNT_W-1:0] CNT_TOP = '1;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] timer_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             drop_q, drop_inc;
  logic             spike_edge;
  logic             accept, win_end, reload;

  spike_edge_sync u_edge_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .spike_edge (spike_edge)
  );

  assign accept   = count_valid & count_ready;
  assign cnt_inc  = (spike_edge && cnt_q != CNT_TOP) ? cnt_q + 1'b1 : cnt_q;
  assign drop_inc = drop_q | (spike_edge & (cnt_q == CNT_TOP));
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    win_end = 1'b0;
    reload  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && window_len != '0) begin
          state_d = COUNT;
          reload  = 1'b1;
        end
      end
      COUNT: begin
        if (timer_q == WIN_W'(1)) begin
          win_end = 1'b1;
          // A zero window_len at rollover cannot start a window, so park in HOLD.
          if (continuous && window_len != '0) reload = 1'b1;
          else state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      count_out   <= '0;
      count_valid <= 1'b0;
      saturated   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == COUNT) begin
        timer_q <= timer_q - 1'b1;
        cnt_q   <= cnt_inc;
        drop_q  <= drop_inc;
      end
      if (reload) begin
        timer_q <= window_len;
        cnt_q   <= '0;
        drop_q  <= 1'b0;
      end
      if (accept) count_valid <= 1'b0;
      // A result loading on the acceptance edge overrides the clear above.
      if (win_end) begin
        count_out   <= cnt_inc;
        saturated   <= drop_inc;
        count_valid <= 1'b1;
        if (count_valid && !count_ready) overrun <= 1'b1;
      end
    end
  end

`ifdef SPIKE_ISI_EN
  localparam logic [ISI_W-1:0] ISI_TOP = '1;

  logic [ISI_W-1:0] isi_cnt_q, isi_q;
  logic             isi_seen_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isi_cnt_q  <= '0;
      isi_q      <= '0;
      isi_seen_q <= 1'b0;
    end else if (spike_edge) begin
      // No previous edge to measure from: report the interval as saturated.
      isi_q      <= isi_seen_q ? isi_cnt_q : ISI_TOP;
      isi_cnt_q  <= ISI_W'(1);
      isi_seen_q <= 1'b1;
    end else if (isi_cnt_q != ISI_TOP) begin
      isi_cnt_q <= isi_cnt_q + 1'b1;
    end
  end

  assign isi_out = isi_q;
`else
  assign isi_out = '0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: default instance plus a CNT_W=4
// instance for saturation; results checked through an expected-count queue.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spike_in;
  logic [7:0] window_len;
  logic       start;
  logic       continuous;
  logic       count_ready;

  logic [7:0] count_out;
  logic       count_valid, busy, saturated, overrun;
  logic [7:0] isi_out;

  logic [3:0] count_out4;
  logic       count_valid4, busy4, saturated4, overrun4;
  logic [7:0] isi_out4;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  spike_rate_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_in    (spike_in),
    .window_len  (window_len),
    .start       (start),
    .continuous  (continuous),
    .count_out   (count_out),
    .count_valid (count_valid),
    .count_ready (count_ready),
    .busy        (busy),
    .saturated   (saturated),
    .overrun     (overrun),
    .isi_out     (isi_out)
  );

  spike_rate_decoder #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_in    (spike_in),
    .window_len  (window_len),
    .start       (start),
    .continuous  (continuous),
    .count_out   (count_out4),
    .count_valid (count_valid4),
    .count_ready (count_ready),
    .busy        (busy4),
    .saturated   (saturated4),
    .overrun     (overrun4),
    .isi_out     (isi_out4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every accepted result of the default instance must match the queue head.
  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (rst_n && count_valid && count_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: count_out=%0d accepted, no result expected", count_out);
        end else begin
          e = exp_q.pop_front();
          if (count_out !== 8'(e)) begin
            errors++;
            $display("FAIL scoreboard_count: count_out=%0d expected=%0d", count_out, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spike_in = 1'b0; window_len = '0; start = 1'b0;
    continuous = 1'b0; count_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({count_out, count_valid, busy, saturated, overrun, isi_out} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got=%h expected=0",
               {count_out, count_valid, busy, saturated, overrun, isi_out});
    end
    checks++;
    if ({count_out4, count_valid4, busy4, saturated4, overrun4} !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs_cnt4: got=%h expected=0",
               {count_out4, count_valid4, busy4, saturated4, overrun4});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_shot();
    window_len = 8'd10; continuous = 1'b0; count_ready = 1'b1;
    for (int i = 0; i <= 15; i++) begin
      start    = (i == 2);
      spike_in = (i >= 1 && i <= 11 && ((i - 1) % 4) != 3);
      if (i == 2) exp_q.push_back(3);
      tick();
      checks++;
      if (busy !== (i >= 2 && i <= 12)) begin
        errors++;
        $display("FAIL single_busy: cycle=%0d busy=%b expected=%b", i, busy, (i >= 2 && i <= 12));
      end
      checks++;
      if (count_valid !== (i == 12)) begin
        errors++;
        $display("FAIL single_valid: cycle=%0d count_valid=%b expected=%b", i, count_valid, (i == 12));
      end
      if (i == 12) begin
        checks++;
        if (count_out !== 8'd3) begin
          errors++;
          $display("FAIL single_count: count_out=%0d expected=3", count_out);
        end
      end
    end
    start = 1'b0; spike_in = 1'b0;
  endtask

  task automatic test_continuous();
    window_len = 8'd4; count_ready = 1'b1;
    for (int i = 0; i <= 19; i++) begin
      continuous = (i < 16);
      start      = (i == 4);
      spike_in   = (i % 2) == 1;
      if (i == 4) begin
        exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2);
      end
      tick();
      checks++;
      if (count_valid !== (i == 8 || i == 12 || i == 16)) begin
        errors++;
        $display("FAIL cont_valid: cycle=%0d count_valid=%b expected=%b", i, count_valid,
                 (i == 8 || i == 12 || i == 16));
      end
      checks++;
      if (busy !== (i >= 4 && i <= 16)) begin
        errors++;
        $display("FAIL cont_busy: cycle=%0d busy=%b expected=%b", i, busy, (i >= 4 && i <= 16));
      end
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL cont_overrun: overrun=%b expected=0", overrun);
    end
    start = 1'b0; spike_in = 1'b0; continuous = 1'b0;
  endtask

  task automatic test_saturation();
    window_len = 8'd200; continuous = 1'b0; count_ready = 1'b1;
    for (int i = 0; i <= 203; i++) begin
      start    = (i == 1);
      spike_in = (i >= 2 && i < 82 && ((i - 2) % 4) < 2);
      if (i == 1) exp_q.push_back(20);
      tick();
      if (i == 201) begin
        checks++;
        if (count_out4 !== 4'd15 || saturated4 !== 1'b1 || count_valid4 !== 1'b1) begin
          errors++;
          $display("FAIL sat_cnt4: count=%0d sat=%b valid=%b expected count=15 sat=1 valid=1",
                   count_out4, saturated4, count_valid4);
        end
        checks++;
        if (count_out !== 8'd20 || saturated !== 1'b0) begin
          errors++;
          $display("FAIL sat_cnt8: count=%0d sat=%b expected count=20 sat=0", count_out, saturated);
        end
      end
    end
    window_len = 8'd10;
    for (int j = 0; j <= 14; j++) begin
      start    = (j == 1);
      spike_in = (j == 2 || j == 3 || j == 6 || j == 7);
      if (j == 1) exp_q.push_back(2);
      tick();
      if (j == 11) begin
        checks++;
        if (count_out4 !== 4'd2 || saturated4 !== 1'b0) begin
          errors++;
          $display("FAIL sat_clear: count=%0d sat=%b expected count=2 sat=0", count_out4, saturated4);
        end
      end
    end
    start = 1'b0; spike_in = 1'b0;
  endtask

  task automatic test_overrun();
    window_len = 8'd6; count_ready = 1'b0;
    for (int i = 0; i <= 13; i++) begin
      continuous = (i < 10);
      start      = (i == 1);
      spike_in   = (i == 2 || i == 3 || i == 6 || i == 9);
      tick();
      if (i == 7) begin
        checks++;
        if (count_valid !== 1'b1 || count_out !== 8'd1 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL ovr_first: valid=%b count=%0d overrun=%b expected valid=1 count=1 overrun=0",
                   count_valid, count_out, overrun);
        end
      end
    end
    checks++;
    if (count_valid !== 1'b1 || count_out !== 8'd2 || overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second: valid=%b count=%0d overrun=%b busy=%b expected 1 2 1 1",
               count_valid, count_out, overrun, busy);
    end
    continuous = 1'b0; spike_in = 1'b0;
    exp_q.push_back(2);
    count_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || count_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_release: busy=%b valid=%b overrun=%b expected 0 0 1", busy, count_valid, overrun);
    end
    window_len = 8'd0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || count_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_window: cycle=%0d busy=%b valid=%b expected 0 0", i, busy, count_valid);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_boundary();
    window_len = 8'd8; continuous = 1'b0; count_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      start    = (i == 2);
      spike_in = (i == 0 || i == 8 || i == 10);
      if (i == 2) exp_q.push_back(1);
      tick();
      if (i == 10) begin
        checks++;
        if (count_valid !== 1'b1 || count_out !== 8'd1) begin
          errors++;
          $display("FAIL boundary_edge: valid=%b count=%0d expected valid=1 count=1", count_valid, count_out);
        end
      end
    end
    start = 1'b0; spike_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    window_len = 8'd20; continuous = 1'b0; count_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      start    = (i == 1);
      spike_in = (i == 3 || i == 4 || i == 7);
      rst_n    = (i != 10);
      tick();
    end
    checks++;
    if ({count_out, count_valid, busy, saturated, overrun, isi_out} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got=%h expected=0",
               {count_out, count_valid, busy, saturated, overrun, isi_out});
    end
    rst_n = 1'b1; start = 1'b0; spike_in = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (count_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet: cycle=%0d valid=%b busy=%b expected 0 0", i, count_valid, busy);
      end
    end
  endtask

  task automatic test_isi();
    logic [7:0] exp_first, exp_second;
`ifdef SPIKE_ISI_EN
    exp_first  = 8'd255;
    exp_second = 8'd7;
`else
    exp_first  = 8'd0;
    exp_second = 8'd0;
`endif
    for (int i = 0; i <= 13; i++) begin
      spike_in = (i == 2 || i == 9);
      tick();
      if (i == 4) begin
        checks++;
        if (isi_out !== exp_first) begin
          errors++;
          $display("FAIL isi_first: isi_out=%0d expected=%0d", isi_out, exp_first);
        end
      end
      if (i == 11) begin
        checks++;
        if (isi_out !== exp_second) begin
          errors++;
          $display("FAIL isi_interval: isi_out=%0d expected=%0d", isi_out, exp_second);
        end
      end
    end
    spike_in = 1'b0;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_shot();
    test_continuous();
    test_saturation();
    test_overrun();
    test_boundary();
    test_reset_mid();
    test_isi();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
